// File: rtl/fifo_sync_prog_pkg.sv
// rtl/fifo_sync_prog_pkg.sv - shared sizing and parameter-check helpers for fifo_sync_prog
package fifo_sync_prog_pkg;

  function automatic int clog2(input int value);
    int r = 0;
    int v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic bit thresh_ok(input int af, input int ae, input int depth);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module fifo_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset so the FIFO output reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with optional FWFT read, programmable
// almost flags and sticky overflow/underflow errors
module fifo_sync_prog
  import fifo_sync_prog_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = 1020,
  parameter int AE_THRESH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_fill,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  generate
    if (!thresh_ok(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
      $error("fifo_sync_prog: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
    end
  endgenerate

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   fill, fill_nxt;
  logic              wr_ok, rd_ok, ram_rd, empty_nxt;

  // Acceptance uses only registered flags: a same-cycle pop never makes room when full.
  assign wr_ok = i_wr && !o_full;
  assign rd_ok = i_rd && !o_empty;

  always_comb begin
    fill_nxt = fill;
    if (wr_ok && !rd_ok)      fill_nxt = fill + 1'b1;
    else if (!wr_ok && rd_ok) fill_nxt = fill - 1'b1;
  end

  generate
    if (FWFT) begin : g_fwft
      // The RAM read register doubles as the output register; !o_empty marks it valid.
      logic [ADDR_W:0] ram_cnt;
      assign ram_cnt   = fill - {{ADDR_W{1'b0}}, !o_empty};
      assign ram_rd    = (ram_cnt != '0) && (o_empty || rd_ok);
      assign empty_nxt = !(ram_rd || (!o_empty && !rd_ok));
    end else begin : g_std
      assign ram_rd    = rd_ok;
      assign empty_nxt = (fill_nxt == '0);
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr           <= '0;
      rptr           <= '0;
      fill           <= '0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_ok)  wptr <= wptr + 1'b1;
      if (ram_rd) rptr <= rptr + 1'b1;
      fill           <= fill_nxt;
      o_empty        <= empty_nxt;
      o_full         <= (fill_nxt == DEPTH_C);
      o_almost_full  <= (fill_nxt >= AF_C);
      o_almost_empty <= (fill_nxt <= AE_C);
      if (i_wr && o_full)  o_overflow <= 1'b1;
      else if (i_clr_err)  o_overflow <= 1'b0;
      if (i_rd && o_empty) o_underflow <= 1'b1;
      else if (i_clr_err)  o_underflow <= 1'b0;
    end
  end

  assign o_fill = fill;

  fifo_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .wr_en   (wr_ok),
    .wr_addr (wptr),
    .wr_data (i_data),
    .rd_en   (ram_rd),
    .rd_addr (rptr),
    .rd_data (o_data)
  );

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - directed bench for fifo_sync_prog in standard, FWFT and default configs
module tb_fifo_sync_prog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [31:0] data = '0;
  logic        d_wr = 1'b0, d_rd = 1'b0, d_clr = 1'b0;
  logic [31:0] d_data = '0;

  logic [31:0] s_data, f_data, d_dout;
  logic        s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
  logic        f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
  logic        d_empty, d_full, d_af, d_ae, d_ovf, d_udf;
  logic [4:0]  s_fill, f_fill;
  logic [10:0] d_fill;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DATA_W(32), .ADDR_W(4), .FWFT(1'b0), .AF_THRESH(14), .AE_THRESH(2)) u_std (
    .i_clk(clk), .i_rstn(rst_n), .i_wr(wr), .i_data(data), .i_rd(rd), .i_clr_err(clr),
    .o_data(s_data), .o_empty(s_empty), .o_full(s_full), .o_fill(s_fill),
    .o_almost_full(s_af), .o_almost_empty(s_ae), .o_overflow(s_ovf), .o_underflow(s_udf));

  fifo_sync_prog #(.DATA_W(32), .ADDR_W(4), .FWFT(1'b1), .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
    .i_clk(clk), .i_rstn(rst_n), .i_wr(wr), .i_data(data), .i_rd(rd), .i_clr_err(clr),
    .o_data(f_data), .o_empty(f_empty), .o_full(f_full), .o_fill(f_fill),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_overflow(f_ovf), .o_underflow(f_udf));

  fifo_sync_prog u_def (
    .i_clk(clk), .i_rstn(rst_n), .i_wr(d_wr), .i_data(d_data), .i_rd(d_rd), .i_clr_err(d_clr),
    .o_data(d_dout), .o_empty(d_empty), .o_full(d_full), .o_fill(d_fill),
    .o_almost_full(d_af), .o_almost_empty(d_ae), .o_overflow(d_ovf), .o_underflow(d_udf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b1; data = 32'h1234_5678; d_wr = 1'b1;
    repeat (3) tick();
    checks++; if ({s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 6'b101000) begin failures++; $display("FAIL reset_std_flags got=%b exp=101000", {s_empty, s_full, s_ae, s_af, s_ovf, s_udf}); end
    checks++; if ({f_empty, f_full, f_ae, f_af, f_ovf, f_udf} !== 6'b101000) begin failures++; $display("FAIL reset_fwft_flags got=%b exp=101000", {f_empty, f_full, f_ae, f_af, f_ovf, f_udf}); end
    checks++; if ({d_empty, d_full, d_ae, d_af, d_ovf, d_udf} !== 6'b101000) begin failures++; $display("FAIL reset_def_flags got=%b exp=101000", {d_empty, d_full, d_ae, d_af, d_ovf, d_udf}); end
    checks++; if (s_fill !== 5'd0 || f_fill !== 5'd0 || d_fill !== 11'd0) begin failures++; $display("FAIL reset_fill got=%0d/%0d/%0d exp=0", s_fill, f_fill, d_fill); end
    checks++; if (s_data !== 32'h0 || f_data !== 32'h0 || d_dout !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", s_data, f_data, d_dout); end
    wr = 1'b0; d_wr = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1 || s_fill !== 5'd0) begin failures++; $display("FAIL reset_release got=%b%b fill=%0d exp=11 fill=0", s_empty, f_empty, s_fill); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data = 32'(i); tick();
    end
    wr = 1'b0;
    checks++; if (s_full !== 1'b1 || f_full !== 1'b1 || s_fill !== 5'd16 || f_fill !== 5'd16) begin failures++; $display("FAIL fill_full got=%b%b fill=%0d/%0d exp=11 fill=16", s_full, f_full, s_fill, f_fill); end
    tick();
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1;
      checks++; if (f_data !== 32'(i)) begin failures++; $display("FAIL drain_fwft_data got=%h exp=%h", f_data, 32'(i)); end
      tick();
      checks++; if (s_data !== 32'(i)) begin failures++; $display("FAIL drain_std_data got=%h exp=%h", s_data, 32'(i)); end
    end
    rd = 1'b0;
    checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1 || s_fill !== 5'd0 || f_fill !== 5'd0) begin failures++; $display("FAIL drain_empty got=%b%b fill=%0d/%0d exp=11 fill=0", s_empty, f_empty, s_fill, f_fill); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data = 32'h100 + 32'(i); tick();
    end
    data = 32'hDEAD_BEEF; tick();
    wr = 1'b0;
    checks++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1 || s_udf !== 1'b0) begin failures++; $display("FAIL overflow_set got=%b%b udf=%b exp=11 udf=0", s_ovf, f_ovf, s_udf); end
    checks++; if (s_fill !== 5'd16 || f_fill !== 5'd16) begin failures++; $display("FAIL overflow_fill got=%0d/%0d exp=16", s_fill, f_fill); end
    tick();
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1;
      checks++; if (f_data !== 32'h100 + 32'(i)) begin failures++; $display("FAIL err_fwft_data got=%h exp=%h", f_data, 32'h100 + 32'(i)); end
      tick();
      checks++; if (s_data !== 32'h100 + 32'(i)) begin failures++; $display("FAIL err_std_data got=%h exp=%h", s_data, 32'h100 + 32'(i)); end
    end
    tick();
    checks++; if (s_udf !== 1'b1 || f_udf !== 1'b1 || s_fill !== 5'd0) begin failures++; $display("FAIL underflow_set got=%b%b fill=%0d exp=11 fill=0", s_udf, f_udf, s_fill); end
    clr = 1'b1; tick();
    checks++; if ({s_ovf, s_udf, f_ovf, f_udf} !== 4'b0101) begin failures++; $display("FAIL clr_set_wins got=%b exp=0101", {s_ovf, s_udf, f_ovf, f_udf}); end
    rd = 1'b0; tick(); clr = 1'b0;
    checks++; if ({s_ovf, s_udf, f_ovf, f_udf} !== 4'b0000) begin failures++; $display("FAIL clr_err got=%b exp=0000", {s_ovf, s_udf, f_ovf, f_udf}); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; data = 32'd200 + 32'(i); tick();
    end
    wr = 1'b0; tick();
    for (int k = 0; k < 20; k++) begin
      wr = 1'b1; rd = 1'b1; data = 32'd205 + 32'(k);
      checks++; if (f_data !== 32'd200 + 32'(k)) begin failures++; $display("FAIL simul_fwft_data got=%0d exp=%0d", f_data, 200 + k); end
      tick();
      checks++; if (s_data !== 32'd200 + 32'(k)) begin failures++; $display("FAIL simul_std_data got=%0d exp=%0d", s_data, 200 + k); end
    end
    rd = 1'b0;
    checks++; if (s_fill !== 5'd5 || f_fill !== 5'd5) begin failures++; $display("FAIL simul_fill got=%0d/%0d exp=5", s_fill, f_fill); end
    for (int i = 0; i < 11; i++) begin
      data = 32'd300 + 32'(i); tick();
    end
    rd = 1'b1; data = 32'hDEAD_BEEF;
    checks++; if (f_data !== 32'd220 || f_full !== 1'b1) begin failures++; $display("FAIL full_rw_fwft got=%0d full=%b exp=220 full=1", f_data, f_full); end
    tick();
    wr = 1'b0;
    checks++; if (s_data !== 32'd220) begin failures++; $display("FAIL full_rw_std_data got=%0d exp=220", s_data); end
    checks++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1 || s_fill !== 5'd15 || f_fill !== 5'd15) begin failures++; $display("FAIL full_rw_flags got=%b%b fill=%0d/%0d exp=11 fill=15", s_ovf, f_ovf, s_fill, f_fill); end
    for (int j = 0; j < 15; j++) begin
      exp = (j < 4) ? 32'd221 + 32'(j) : 32'd300 + 32'(j - 4);
      checks++; if (f_data !== exp) begin failures++; $display("FAIL tail_fwft_data got=%0d exp=%0d", f_data, exp); end
      tick();
      checks++; if (s_data !== exp) begin failures++; $display("FAIL tail_std_data got=%0d exp=%0d", s_data, exp); end
    end
    rd = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1 || s_ovf !== 1'b0) begin failures++; $display("FAIL simul_end got=%b%b ovf=%b exp=11 ovf=0", s_empty, f_empty, s_ovf); end
  endtask

  task automatic test_thresholds();
    logic e_ae, e_af;
    for (int k = 1; k <= 16; k++) begin
      wr = 1'b1; data = 32'(k); tick();
      e_ae = (k <= 2); e_af = (k >= 14);
      checks++; if ({s_ae, s_af, f_ae, f_af} !== {e_ae, e_af, e_ae, e_af}) begin failures++; $display("FAIL thresh_up fill=%0d got=%b exp=%b", k, {s_ae, s_af, f_ae, f_af}, {e_ae, e_af, e_ae, e_af}); end
    end
    wr = 1'b0; tick();
    for (int k = 15; k >= 0; k--) begin
      rd = 1'b1; tick();
      e_ae = (k <= 2); e_af = (k >= 14);
      checks++; if ({s_ae, s_af, f_ae, f_af} !== {e_ae, e_af, e_ae, e_af}) begin failures++; $display("FAIL thresh_down fill=%0d got=%b exp=%b", k, {s_ae, s_af, f_ae, f_af}, {e_ae, e_af, e_ae, e_af}); end
    end
    rd = 1'b0;
  endtask

  task automatic test_default();
    for (int i = 0; i < 5; i++) begin
      d_wr = 1'b1; d_data = 32'hC000 + 32'(i); tick();
    end
    d_wr = 1'b0;
    checks++; if (d_fill !== 11'd5 || {d_empty, d_ae, d_af, d_full} !== 4'b0000) begin failures++; $display("FAIL default_fill got=%0d flags=%b exp=5 flags=0000", d_fill, {d_empty, d_ae, d_af, d_full}); end
    d_rd = 1'b1; tick(); d_rd = 1'b0;
    checks++; if (d_dout !== 32'hC000 || d_fill !== 11'd4 || d_ae !== 1'b1) begin failures++; $display("FAIL default_read got=%h fill=%0d ae=%b exp=c000 fill=4 ae=1", d_dout, d_fill, d_ae); end
  endtask

  task automatic test_fwft_latency();
    wr = 1'b1; data = 32'hA5A5_A5A5; tick();
    wr = 1'b0;
    checks++; if (f_empty !== 1'b1 || s_empty !== 1'b0) begin failures++; $display("FAIL fwft_edge_n got=f%b s%b exp=f1 s0", f_empty, s_empty); end
    tick();
    checks++; if (f_empty !== 1'b0 || f_data !== 32'hA5A5_A5A5) begin failures++; $display("FAIL fwft_edge_n1 got=%b %h exp=0 a5a5a5a5", f_empty, f_data); end
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; data = 32'h50 + 32'(i); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({s_empty, f_empty} !== 2'b11 || s_fill !== 5'd0 || f_fill !== 5'd0 || d_fill !== 11'd0) begin failures++; $display("FAIL async_reset got=%b fill=%0d/%0d/%0d exp=11 fill=0", {s_empty, f_empty}, s_fill, f_fill, d_fill); end
    checks++; if (f_data !== 32'h0 || s_data !== 32'h0) begin failures++; $display("FAIL async_reset_data got=%h/%h exp=0", s_data, f_data); end
    wr = 1'b0; tick();
    rst_n = 1'b1; tick();
    checks++; if ({s_empty, f_empty} !== 2'b11 || s_fill !== 5'd0) begin failures++; $display("FAIL post_reset got=%b fill=%0d exp=11 fill=0", {s_empty, f_empty}, s_fill); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_errors();
    test_simultaneous();
    test_thresholds();
    test_default();
    test_fwft_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
